alu_seq_nbit: RTL and testbench



---
 rtl/alu_seq_nbit.sv | 156 +++++++++++++++
 tb/tb_alu_seq_nbit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_nbit.sv
// Multi-cycle unsigned ALU: ADD/SUB take one cycle, MUL runs a shift-add loop
// and DIV runs a restoring loop, WIDTH iterations each. Operands come in and
// results go out through valid/ready handshakes.
module alu_seq_nbit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 status,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [2*WIDTH-1:0]   a_q, a_d;       // multiplicand, shifted left per MUL step
  logic [WIDTH-1:0]     b_q, b_d;       // multiplier (shifted right) or divisor
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // product accumulator
  logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]     quo_q, quo_d;   // dividend shifted out MSB first, quotient shifted in
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 status_q, status_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   diff;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_sub;
  logic                 rem_ge;

  assign sum     = {1'b0, a_q[WIDTH-1:0]} + {1'b0, b_q};
  assign diff    = {{WIDTH{1'b0}}, a_q[WIDTH-1:0]} - {{WIDTH{1'b0}}, b_q};
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  // Partial remainder is always below 2*b, so a set top bit means rem_sh < b.
  assign rem_ge  = ~rem_sub[WIDTH];

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign status    = status_q;

  // Next-state, datapath iteration and result capture on entry to DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          op_d    = op_t'(op);
          a_d     = {{WIDTH{1'b0}}, a};
          b_d     = b;
          acc_d   = '0;
          rem_d   = '0;
          quo_d   = a;
          if ((op_t'(op) == OP_MUL) || ((op_t'(op) == OP_DIV) && (b != '0)))
            cnt_d = CW'(WIDTH);
          else
            cnt_d = '0;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (op_q == OP_MUL) begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
          end else begin
            rem_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], rem_ge};
          end
        end else begin
          state_d = DONE;
          case (op_q)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum};
              status_d = sum[WIDTH];
            end
            OP_SUB: begin
              result_d = diff;
              status_d = (b_q > a_q[WIDTH-1:0]);
            end
            OP_MUL: begin
              result_d = acc_q;
              status_d = |acc_q[2*WIDTH-1:WIDTH];
            end
            default: begin
              if (b_q == '0) begin
                result_d = '1;
                status_d = 1'b1;
              end else begin
                result_d = {rem_q, quo_q};
                status_d = 1'b0;
              end
            end
          endcase
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed, table-driven bench for alu_seq_nbit at WIDTH=4.
module tb_alu_seq_nbit;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           status;
  logic           busy;

  int errors = 0;
  int checks = 0;

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           st;
    int             lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts an operation at a negedge in IDLE and waits for out_valid (no handshake).
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string name, output int lat, output int bcnt);
    chk({name, " in_ready before accept"}, 64'(in_ready), 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = '0; b = '0; op = 2'd0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (busy) bcnt++;
    end
    if (!out_valid) chk({name, " timeout waiting out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
    chk({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    vecs[0]  = '{2'd0, 4'd15, 4'd1,  8'h10, 1'b1, 1};
    vecs[1]  = '{2'd0, 4'd7,  4'd8,  8'h0F, 1'b0, 1};
    vecs[2]  = '{2'd0, 4'd15, 4'd15, 8'h1E, 1'b1, 1};
    vecs[3]  = '{2'd1, 4'd3,  4'd5,  8'hFE, 1'b1, 1};
    vecs[4]  = '{2'd1, 4'd5,  4'd3,  8'h02, 1'b0, 1};
    vecs[5]  = '{2'd1, 4'd0,  4'd15, 8'hF1, 1'b1, 1};
    vecs[6]  = '{2'd1, 4'd9,  4'd9,  8'h00, 1'b0, 1};
    vecs[7]  = '{2'd2, 4'd15, 4'd15, 8'hE1, 1'b1, 5};
    vecs[8]  = '{2'd2, 4'd3,  4'd2,  8'h06, 1'b0, 5};
    vecs[9]  = '{2'd2, 4'd0,  4'd9,  8'h00, 1'b0, 5};
    vecs[10] = '{2'd2, 4'd7,  4'd0,  8'h00, 1'b0, 5};
    vecs[11] = '{2'd2, 4'd4,  4'd4,  8'h10, 1'b1, 5};
    vecs[12] = '{2'd3, 4'd13, 4'd4,  8'h13, 1'b0, 5};
    vecs[13] = '{2'd3, 4'd9,  4'd0,  8'hFF, 1'b1, 1};
    vecs[14] = '{2'd3, 4'd15, 4'd1,  8'h0F, 1'b0, 5};
    vecs[15] = '{2'd3, 4'd3,  4'd7,  8'h30, 1'b0, 5};
    vecs[16] = '{2'd3, 4'd15, 4'd15, 8'h01, 1'b0, 5};
    vecs[17] = '{2'd3, 4'd14, 4'd3,  8'h24, 1'b0, 5};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset status", 64'(status), 64'd0);

    for (int i = 0; i < 18; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, nm, lat, bcnt);
      chk({nm, " result"}, 64'(result), 64'(vecs[i].res));
      chk({nm, " status"}, 64'(status), 64'(vecs[i].st));
      chk({nm, " latency"}, 64'(lat), 64'(vecs[i].lat));
      chk({nm, " busy cycles"}, 64'(bcnt), 64'(vecs[i].lat));
      release_out(nm);
    end

    // Backpressure: result held while out_ready is low; accepts are ignored.
    do_op(2'd2, 4'd15, 4'd15, "bp", lat, bcnt);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; op = 2'd0; a = 4'd1; b = 4'd1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp result stable", 64'(result), 64'hE1);
      chk("bp status stable", 64'(status), 64'd1);
      chk("bp out_valid held", 64'(out_valid), 64'd1);
      chk("bp in_ready low", 64'(in_ready), 64'd0);
      chk("bp busy low", 64'(busy), 64'd0);
    end
    release_out("bp");
    chk("bp result held in idle", 64'(result), 64'hE1);

    // Reset during the third BUSY cycle of a DIV.
    op = 2'd3; a = 4'd13; b = 4'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort busy before rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort status", 64'(status), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid || busy) seen++;
      end
      chk("abort no late activity", 64'(seen), 64'd0);
    end
    do_op(2'd0, 4'd2, 4'd2, "post", lat, bcnt);
    chk("post result", 64'(result), 64'h04);
    chk("post status", 64'(status), 64'd0);
    chk("post latency", 64'(lat), 64'd1);
    release_out("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
